// File: rtl/coin_hopper_ctrl_if.sv
// rtl/coin_hopper_ctrl_if.sv - dispense request, hopper sensor/motor and status bundle
interface coin_hopper_ctrl_if #(
    parameter int TOT_W = 10
);
    logic             dispQuarter;
    logic             dispDime;
    logic             dispNickel;
    logic             exitQ;
    logic             exitD;
    logic             exitN;
    logic             emptyQ;
    logic             emptyD;
    logic             emptyN;
    logic             clrFault;
    logic             motQ;
    logic             motD;
    logic             motN;
    logic             busy;
    logic             fault;
    logic [1:0]       faultCode;
    logic             ovf;
    logic [TOT_W-1:0] owed;
    logic [TOT_W-1:0] paid;

    modport master (
        output dispQuarter, dispDime, dispNickel,
        output exitQ, exitD, exitN,
        output emptyQ, emptyD, emptyN,
        output clrFault,
        input  motQ, motD, motN, busy, fault, faultCode, ovf, owed, paid
    );

    modport slave (
        input  dispQuarter, dispDime, dispNickel,
        input  exitQ, exitD, exitN,
        input  emptyQ, emptyD, emptyN,
        input  clrFault,
        output motQ, motD, motN, busy, fault, faultCode, ovf, owed, paid
    );
endinterface

// File: rtl/coin_hopper_ctrl.sv
// rtl/coin_hopper_ctrl.sv - queues change requests per denomination and drives hoppers one coin at a time
module coin_hopper_ctrl #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 50,
    parameter int GAP     = 3,
    parameter int TOT_W   = 10
) (
    input  logic              clk,
    input  logic              rst,
    coin_hopper_ctrl_if.slave bus
);
    localparam int TMR_W = $clog2(((TIMEOUT > GAP) ? TIMEOUT : GAP) + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [1:0] SEL_Q = 2'd0;
    localparam logic [1:0] SEL_D = 2'd1;
    localparam logic [1:0] SEL_N = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP - 1);

    logic [1:0]       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] pend_qtr_q, pend_qtr_d;
    logic [CNT_W-1:0] pend_dime_q, pend_dime_d;
    logic [CNT_W-1:0] pend_nick_q, pend_nick_d;
    logic [TOT_W-1:0] paid_q, paid_d;
    logic [1:0]       code_q, code_d;
    logic             ovf_q, ovf_d;

    logic             confirm;
    logic             dec_qtr, dec_dime, dec_nick;
    logic             ovf_set;
    logic             pick_valid, pick_empty;
    logic [1:0]       pick_sel;
    logic [TOT_W-1:0] sel_value;

    // A request and a confirmed exit in the same cycle cancel; a lone request at max is dropped.
    function automatic logic [CNT_W-1:0] next_pend(input logic [CNT_W-1:0] cur,
                                                   input logic inc, input logic dec);
        if (inc == dec)
            return cur;
        if (inc)
            return (cur == CNT_MAX) ? cur : cur + 1'b1;
        return cur - 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        paid_d      = paid_q;
        code_d      = code_q;
        pick_valid  = 1'b1;
        pick_sel    = SEL_Q;
        pick_empty  = bus.emptyQ;
        sel_value   = TOT_W'(0);

        case (sel_q)
            SEL_Q:   sel_value = TOT_W'(25);
            SEL_D:   sel_value = TOT_W'(10);
            SEL_N:   sel_value = TOT_W'(5);
            default: sel_value = TOT_W'(0);
        endcase

        confirm  = (state_q == ST_RUN) &&
                   (((sel_q == SEL_Q) && bus.exitQ) ||
                    ((sel_q == SEL_D) && bus.exitD) ||
                    ((sel_q == SEL_N) && bus.exitN));
        dec_qtr  = confirm && (sel_q == SEL_Q);
        dec_dime = confirm && (sel_q == SEL_D);
        dec_nick = confirm && (sel_q == SEL_N);

        pend_qtr_d  = next_pend(pend_qtr_q,  bus.dispQuarter, dec_qtr);
        pend_dime_d = next_pend(pend_dime_q, bus.dispDime,    dec_dime);
        pend_nick_d = next_pend(pend_nick_q, bus.dispNickel,  dec_nick);

        ovf_set = (bus.dispQuarter && (pend_qtr_q  == CNT_MAX) && !dec_qtr)  ||
                  (bus.dispDime    && (pend_dime_q == CNT_MAX) && !dec_dime) ||
                  (bus.dispNickel  && (pend_nick_q == CNT_MAX) && !dec_nick);
        ovf_d   = (ovf_q && !bus.clrFault) || ovf_set;

        if (pend_qtr_q != '0) begin
            pick_sel   = SEL_Q;
            pick_empty = bus.emptyQ;
        end else if (pend_dime_q != '0) begin
            pick_sel   = SEL_D;
            pick_empty = bus.emptyD;
        end else if (pend_nick_q != '0) begin
            pick_sel   = SEL_N;
            pick_empty = bus.emptyN;
        end else begin
            pick_valid = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_sel;
                    timer_d = '0;
                    if (pick_empty) begin
                        state_d = ST_FAULT;
                        code_d  = 2'b10;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                timer_d = timer_q + 1'b1;
                if (confirm) begin
                    state_d = ST_GAP;
                    timer_d = '0;
                    paid_d  = paid_q + sel_value;
                end else if (timer_q == TMO_LAST) begin
                    state_d = ST_FAULT;
                    code_d  = 2'b01;
                end
            end
            ST_GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                // sel_q is left alone so the next selection retries the faulted hopper.
                if (bus.clrFault) begin
                    state_d = ST_IDLE;
                    code_d  = 2'b00;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= SEL_Q;
            timer_q     <= '0;
            pend_qtr_q  <= '0;
            pend_dime_q <= '0;
            pend_nick_q <= '0;
            paid_q      <= '0;
            code_q      <= 2'b00;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            pend_qtr_q  <= pend_qtr_d;
            pend_dime_q <= pend_dime_d;
            pend_nick_q <= pend_nick_d;
            paid_q      <= paid_d;
            code_q      <= code_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.motQ      = (state_q == ST_RUN) && (sel_q == SEL_Q);
    assign bus.motD      = (state_q == ST_RUN) && (sel_q == SEL_D);
    assign bus.motN      = (state_q == ST_RUN) && (sel_q == SEL_N);
    assign bus.busy      = (state_q != ST_IDLE) || (pend_qtr_q != '0) ||
                           (pend_dime_q != '0) || (pend_nick_q != '0);
    assign bus.fault     = (state_q == ST_FAULT);
    assign bus.faultCode = code_q;
    assign bus.ovf       = ovf_q;
    assign bus.paid      = paid_q;
    assign bus.owed      = TOT_W'(25) * TOT_W'(pend_qtr_q) +
                           TOT_W'(10) * TOT_W'(pend_dime_q) +
                           TOT_W'(5)  * TOT_W'(pend_nick_q);
endmodule

// File: tb/tb_coin_hopper_ctrl.sv
// tb/tb_coin_hopper_ctrl.sv - directed scoreboard bench for coin_hopper_ctrl
module tb_coin_hopper_ctrl;
    localparam int TOT_W   = 10;
    localparam int TIMEOUT = 50;
    localparam int GAP     = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    coin_hopper_ctrl_if #(.TOT_W(TOT_W)) bus ();

    coin_hopper_ctrl #(.CNT_W(4), .TIMEOUT(TIMEOUT), .GAP(GAP), .TOT_W(TOT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;
    int sb[$];
    int exp_paid = 0;
    int exp_owed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int coin_val(input int d);
        return (d == 0) ? 25 : (d == 1) ? 10 : 5;
    endfunction

    function automatic int mot_now();
        if (bus.motQ) return 0;
        if (bus.motD) return 1;
        if (bus.motN) return 2;
        return -1;
    endfunction

    task automatic clear_inputs();
        bus.dispQuarter = 0; bus.dispDime = 0; bus.dispNickel = 0;
        bus.exitQ = 0; bus.exitD = 0; bus.exitN = 0;
        bus.emptyQ = 0; bus.emptyD = 0; bus.emptyN = 0;
        bus.clrFault = 0;
    endtask

    task automatic do_reset(input string tag);
        rst = 0;
        clear_inputs();
        sb.delete();
        exp_paid = 0;
        exp_owed = 0;
        step();
        step();
        chk({tag, "_rst_mot"}, {bus.motQ, bus.motD, bus.motN}, 0);
        chk({tag, "_rst_busy"}, bus.busy, 0);
        chk({tag, "_rst_owed"}, bus.owed, 0);
        chk({tag, "_rst_paid"}, bus.paid, 0);
        chk({tag, "_rst_flt"}, {bus.fault, bus.faultCode, bus.ovf}, 0);
        rst = 1;
        step();
    endtask

    task automatic set_disp(input int d, input logic v);
        case (d)
            0: bus.dispQuarter = v;
            1: bus.dispDime    = v;
            default: bus.dispNickel = v;
        endcase
    endtask

    task automatic set_exit(input int d, input logic v);
        case (d)
            0: bus.exitQ = v;
            1: bus.exitD = v;
            default: bus.exitN = v;
        endcase
    endtask

    task automatic req(input int d, input bit track);
        set_disp(d, 1);
        if (track) sb.push_back(d);
        exp_owed += coin_val(d);
        step();
        set_disp(d, 0);
    endtask

    task automatic pulse_clr();
        bus.clrFault = 1;
        step();
        bus.clrFault = 0;
    endtask

    task automatic wait_motor(output int which, input int budget);
        which = mot_now();
        for (int i = 0; i < budget && which < 0; i++) begin
            step();
            which = mot_now();
        end
    endtask

    task automatic serve(input string tag, input int hold);
        int which;
        int exp;
        wait_motor(which, 200);
        exp = (sb.size() == 0) ? -2 : sb.pop_front();
        chk({tag, "_motor"}, which, exp);
        if (which >= 0) begin
            repeat (hold) step();
            set_exit(which, 1);
            step();
            set_exit(which, 0);
            exp_paid += coin_val(which);
            exp_owed -= coin_val(which);
        end
        chk({tag, "_mot_off"}, {bus.motQ, bus.motD, bus.motN}, 0);
        chk({tag, "_paid"}, bus.paid, exp_paid);
        chk({tag, "_owed"}, bus.owed, exp_owed);
    endtask

    initial begin
        int off;
        int hi;
        int which;
        bit seen;

        clear_inputs();

        // 1: dime then nickel, motor latency and inter-coin gap
        do_reset("t1");
        bus.dispDime = 1; sb.push_back(1); exp_owed += 10;
        step();
        bus.dispDime = 0; bus.dispNickel = 1; sb.push_back(2); exp_owed += 5;
        chk("t1_motd_early", bus.motD, 0);
        chk("t1_owed10", bus.owed, 10);
        step();
        bus.dispNickel = 0;
        chk("t1_motd_on", bus.motD, 1);
        serve("t1_dime", 4);
        off = 0;
        while (mot_now() < 0 && off < 20) begin
            step();
            off++;
        end
        chk("t1_gap_cycles", off, GAP + 1);
        serve("t1_nick", 2);
        chk("t1_busy_gap", bus.busy, 1);
        repeat (GAP) step();
        chk("t1_busy_done", bus.busy, 0);

        // 2: quarter and nickel together, quarter first
        do_reset("t2");
        bus.dispQuarter = 1; bus.dispNickel = 1;
        sb.push_back(0); sb.push_back(2); exp_owed = 30;
        step();
        bus.dispQuarter = 0; bus.dispNickel = 0;
        chk("t2_owed30", bus.owed, 30);
        step();
        chk("t2_motn_held", bus.motN, 0);
        serve("t2_qtr", 3);
        serve("t2_nick", 1);
        chk("t2_paid30", bus.paid, 30);

        // 3: jam timeout, then clear and retry the same hopper
        do_reset("t3");
        req(0, 1'b0);
        wait_motor(which, 20);
        chk("t3_motq", which, 0);
        hi = 0;
        while (bus.motQ && hi < 200) begin
            hi++;
            step();
        end
        chk("t3_high_cycles", hi, TIMEOUT);
        chk("t3_fault", bus.fault, 1);
        chk("t3_code", bus.faultCode, 2'b01);
        chk("t3_owed", bus.owed, 25);
        pulse_clr();
        chk("t3_fault_clr", {bus.fault, bus.faultCode}, 0);
        sb.push_back(0);
        serve("t3_retry", 3);
        chk("t3_fault_end", bus.fault, 0);

        // 4: empty hopper at selection
        do_reset("t4");
        bus.emptyD = 1;
        req(1, 1'b0);
        step();
        chk("t4_fault", bus.fault, 1);
        chk("t4_code", bus.faultCode, 2'b10);
        chk("t4_owed", bus.owed, 10);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.motD) seen = 1;
            step();
        end
        chk("t4_no_motd", seen, 0);
        bus.emptyD = 0;
        pulse_clr();
        chk("t4_code_clr", bus.faultCode, 0);
        sb.push_back(1);
        serve("t4_dime", 2);

        // 5: nickel counter saturation
        do_reset("t5");
        for (int i = 0; i < 15; i++) req(2, 1'b0);
        chk("t5_ovf_at15", bus.ovf, 0);
        req(2, 1'b0);
        chk("t5_owed75", bus.owed, 75);
        chk("t5_ovf", bus.ovf, 1);
        step();
        chk("t5_ovf_sticky", bus.ovf, 1);
        pulse_clr();
        chk("t5_ovf_clr", bus.ovf, 0);
        chk("t5_no_fault", bus.fault, 0);

        // 6: asynchronous reset while a motor runs
        do_reset("t6");
        req(0, 1'b1);
        serve("t6_first", 2);
        req(0, 1'b1);
        wait_motor(which, 20);
        chk("t6_motq", which, 0);
        step();
        #2 rst = 0;
        #1;
        chk("t6_async_mot", bus.motQ, 0);
        chk("t6_async_owed", bus.owed, 0);
        chk("t6_async_paid", bus.paid, 0);
        chk("t6_async_busy", bus.busy, 0);
        sb.delete();
        step();
        rst = 1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (mot_now() >= 0 || bus.busy) seen = 1;
        end
        chk("t6_quiet", seen, 0);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coin_hopper_ctrl.md
Name: coin_hopper_ctrl

Overview:
Change-dispense back end for the vending controller. It receives the single-cycle dispQuarter/dispDime/dispNickel pulses from the vending controller and queues them per denomination. It then drives three coin-hopper motors, one coin at a time, and confirms each coin with its exit sensor. It reports amount owed and paid out, jams (timeout), empty hoppers and queue overflow.

Parameters:
CNT_W, 4, width of each per-denomination pending counter (max 2^CNT_W-1 coins queued)
TIMEOUT, 50, max cycles in RUN waiting for the exit pulse
GAP, 3, motor-off cycles between consecutive coins
TOT_W, 10, width of the owed/paid cent counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
dispQuarter  in  1  one-cycle request: dispense one 25c coin
dispDime  in  1  one-cycle request: dispense one 10c coin
dispNickel  in  1  one-cycle request: dispense one 5c coin
exitQ / exitD / exitN  in  1 each  one-cycle coin-exit sensor pulse per hopper, synchronous to clk
emptyQ / emptyD / emptyN  in  1 each  level, hopper empty
clrFault  in  1  one-cycle pulse, clears fault and ovf
motQ / motD / motN  out  1 each  hopper motor enables, at most one high
busy  out  1  state != IDLE or any pending count nonzero
fault  out  1  state == FAULT
faultCode  out  2  00 none, 01 timeout/jam, 10 hopper empty
ovf  out  1  sticky, a request arrived with its counter at max
owed  out  TOT_W  cents queued: 25*pendQ + 10*pendD + 5*pendN (combinational from counters)
paid  out  TOT_W  cents confirmed dispensed since reset, wraps modulo 2^TOT_W

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; pendQ/D/N, timer, paid = 0; mot* = 0; fault = 0; faultCode = 00; ovf = 0; busy = 0; owed = 0.
- Request capture, every state:
  - dispX high at edge -> pendX+1.
  - Requests for different denominations in the same cycle are all counted.
  - A request and a confirmed exit for the same denomination in the same cycle -> net change 0.
  - At max count the counter holds and ovf is set. ovf is cleared only by clrFault or reset.
- FSM states: IDLE, RUN, GAP, FAULT. Motor outputs are decoded from registered state and the registered select.
- IDLE:
  - Select the first nonzero counter in priority Q > D > N.
  - If the selected hopper's emptyX = 1 -> FAULT, faultCode 10, no motor pulse.
  - Otherwise -> RUN with sel latched and timer = 0.
  - Latency: request pulse at edge n -> counter at n+1 -> RUN and motX high from edge n+2.
- RUN:
  - motX for sel high; timer increments each cycle.
  - exit pulse of sel -> pendX-1, paid += value, -> GAP (motor low next cycle).
  - Exit pulses of the non-selected hoppers are ignored.
  - timer reaches TIMEOUT-1 with no exit -> FAULT, faultCode 01. Motor low after exactly TIMEOUT cycles high. Pending count is kept.
- GAP: all motors low for GAP cycles, then IDLE.
- FAULT:
  - All motors low; requests keep accumulating.
  - clrFault -> IDLE, faultCode 00, ovf 0. The next selection then retries the same denomination.
- clrFault outside FAULT clears ovf only.
- emptyX is sampled only at selection in IDLE; a hopper going empty during RUN is caught by the timeout.
- Arithmetic: owed and paid are unsigned TOT_W bits. With the defaults, owed max = 15*40 = 600, which fits in 10 bits.

Test Plan:
1. Change sequence: dispDime then dispNickel; exitD 5 cycles after motD rises.
   -> motD high from the second edge after the request and low after exitD.
   -> 3 GAP cycles, then motN runs; exitN.
   -> paid = 15, owed = 0, busy drops.
2. dispQuarter and dispNickel in the same cycle.
   -> owed = 30; motQ served first, motN only after exitQ plus GAP.
   -> paid = 30 at the end.
3. Jam: dispQuarter with exitQ never pulsed.
   -> motQ high exactly 50 cycles, then fault = 1, faultCode 01, owed = 25.
   -> clrFault: motQ rises again; exitQ -> paid = 25, fault clear.
4. Empty: emptyD = 1, dispDime.
   -> FAULT, faultCode 10, motD never asserted, owed = 10.
   -> clear emptyD, clrFault -> dime dispensed, paid = 10.
5. Overflow: 16 consecutive dispNickel pulses with exitN held low.
   -> pendN saturates at 15, owed = 75, ovf = 1 (cleared by clrFault).
6. Reset mid-RUN: drop rst while motQ is high.
   -> motQ low immediately (asynchronously), owed = 0, paid = 0, busy = 0.
   -> after release, no motor activity without new requests.
